// File: rtl/qam_stream_modulator.sv
// Symbol-FIFO fed BPSK/QPSK/16-QAM/64-QAM modulator: I*aI + Q*aQ through a 2-stage pipeline.
// Optional saturating underrun counter enabled by defining QAMMOD_UNDERRUN_CNT_EN.
module qam_stream_modulator #(
  parameter int CARRIER_W  = 18,
  parameter int FIFO_DEPTH = 16,
  localparam int OUT_W     = CARRIER_W + 5,
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                        ipClk,
  input  logic                        ipReset,
  input  logic                        ipEnable,
  input  logic [1:0]                  ipMode,
  input  logic [15:0]                 ipSymPeriod,
  input  logic [5:0]                  ipSym,
  input  logic                        ipSymValid,
  output logic                        opSymReady,
  input  logic signed [CARRIER_W-1:0] ipI,
  input  logic signed [CARRIER_W-1:0] ipQ,
  output logic signed [OUT_W-1:0]     opModulated,
  output logic                        opModulatedValid,
  output logic                        opSymStrobe,
  output logic                        opUnderrun,
`ifdef QAMMOD_UNDERRUN_CNT_EN
  input  logic                        ipUnderrunClear,
  output logic [15:0]                 opUnderrunCount,
`endif
  output logic [CNT_W-1:0]            opFIFO_Count,
  output logic                        opBusy
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int PROD_W = CARRIER_W + 4;

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e state_q, state_d;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [5:0]       mem_q [FIFO_DEPTH];
  logic             ready_en_q;
  logic             push, start;

  logic [15:0]        tick_q, tick_d, period_q, period_d, eff_period;
  logic signed [3:0]  lvl_ich_q, lvl_ich_d, lvl_qch_q, lvl_qch_d;
  logic               underrun_q, underrun_d;
  logic               last_tick;

  logic signed [PROD_W-1:0] prod_i_q, prod_i_d, prod_q_q, prod_q_d;
  logic signed [OUT_W-1:0]  sum_q, sum_d;
  logic [1:0]               valid_pipe_q, valid_pipe_d, strobe_pipe_q, strobe_pipe_d;

  function automatic logic signed [3:0] gray2(input logic [1:0] b);
    case (b)
      2'b00:   return -4'sd6;
      2'b01:   return -4'sd2;
      2'b11:   return 4'sd2;
      default: return 4'sd6;
    endcase
  endfunction

  function automatic logic signed [3:0] gray3(input logic [2:0] b);
    case (b)
      3'b000:  return -4'sd7;
      3'b001:  return -4'sd5;
      3'b011:  return -4'sd3;
      3'b010:  return -4'sd1;
      3'b110:  return 4'sd1;
      3'b111:  return 4'sd3;
      3'b101:  return 4'sd5;
      default: return 4'sd7;
    endcase
  endfunction

  // Returns {aI, aQ}.
  function automatic logic [7:0] map_levels(input logic [1:0] mode, input logic [5:0] sym);
    logic signed [3:0] ai, aq;
    case (mode)
      2'd0: begin
        ai = sym[0] ? 4'sd7 : -4'sd7;
        aq = 4'sd0;
      end
      2'd1: begin
        ai = sym[1] ? 4'sd5 : -4'sd5;
        aq = sym[0] ? 4'sd5 : -4'sd5;
      end
      2'd2: begin
        ai = gray2(sym[3:2]);
        aq = gray2(sym[1:0]);
      end
      default: begin
        ai = gray3(sym[5:3]);
        aq = gray3(sym[2:0]);
      end
    endcase
    return {ai, aq};
  endfunction

  // FIFO: ready is held low until the first clock after reset release.
  assign opSymReady = ready_en_q && (count_q < CNT_W'(FIFO_DEPTH));
  assign push       = ipSymValid && opSymReady;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (start) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !start) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && start) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge ipClk) begin
    if (push) mem_q[wr_ptr_q] <= ipSym;
  end

  // Symbol sequencer.
  assign eff_period = (ipSymPeriod == 16'd0) ? 16'd1 : ipSymPeriod;
  assign last_tick  = (tick_q == period_q - 16'd1);

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    period_d   = period_q;
    lvl_ich_d  = lvl_ich_q;
    lvl_qch_d  = lvl_qch_q;
    underrun_d = 1'b0;
    start      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ipEnable && count_q != '0) start = 1'b1;
      end
      StActive: begin
        if (last_tick) begin
          if (ipEnable && count_q != '0) begin
            start = 1'b1;
          end else begin
            state_d    = StIdle;
            lvl_ich_d  = 4'sd0;
            lvl_qch_d  = 4'sd0;
            underrun_d = ipEnable;
          end
        end else begin
          tick_d = tick_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (start) begin
      state_d                = StActive;
      tick_d                 = 16'd0;
      period_d               = eff_period;
      {lvl_ich_d, lvl_qch_d} = map_levels(ipMode, mem_q[rd_ptr_q]);
    end
  end

  // Datapath: products, then sum; valid/strobe ride alongside.
  always_comb begin
    prod_i_d      = PROD_W'(ipI) * PROD_W'(lvl_ich_q);
    prod_q_d      = PROD_W'(ipQ) * PROD_W'(lvl_qch_q);
    sum_d         = OUT_W'(prod_i_q) + OUT_W'(prod_q_q);
    valid_pipe_d  = {valid_pipe_q[0], state_q == StActive};
    strobe_pipe_d = {strobe_pipe_q[0], (state_q == StActive) && (tick_q == 16'd0)};
  end

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      state_q       <= StIdle;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      ready_en_q    <= 1'b0;
      tick_q        <= '0;
      period_q      <= 16'd1;
      lvl_ich_q     <= '0;
      lvl_qch_q     <= '0;
      underrun_q    <= 1'b0;
      prod_i_q      <= '0;
      prod_q_q      <= '0;
      sum_q         <= '0;
      valid_pipe_q  <= '0;
      strobe_pipe_q <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      ready_en_q    <= 1'b1;
      tick_q        <= tick_d;
      period_q      <= period_d;
      lvl_ich_q     <= lvl_ich_d;
      lvl_qch_q     <= lvl_qch_d;
      underrun_q    <= underrun_d;
      prod_i_q      <= prod_i_d;
      prod_q_q      <= prod_q_d;
      sum_q         <= sum_d;
      valid_pipe_q  <= valid_pipe_d;
      strobe_pipe_q <= strobe_pipe_d;
    end
  end

`ifdef QAMMOD_UNDERRUN_CNT_EN
  logic [15:0] urun_cnt_q, urun_cnt_d;

  // Clear has priority over a coincident underrun.
  always_comb begin
    urun_cnt_d = urun_cnt_q;
    if (ipUnderrunClear) begin
      urun_cnt_d = 16'd0;
    end else if (underrun_q && urun_cnt_q != 16'hFFFF) begin
      urun_cnt_d = urun_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) urun_cnt_q <= '0;
    else          urun_cnt_q <= urun_cnt_d;
  end

  assign opUnderrunCount = urun_cnt_q;
`endif

  assign opModulated      = sum_q;
  assign opModulatedValid = valid_pipe_q[1];
  assign opSymStrobe      = strobe_pipe_q[1];
  assign opUnderrun       = underrun_q;
  assign opFIFO_Count     = count_q;
  assign opBusy           = (state_q == StActive);

endmodule

// File: tb/tb_qam_stream_modulator.sv
// Scoreboard bench for qam_stream_modulator; exercises the underrun counter when
// QAMMOD_UNDERRUN_CNT_EN is defined.
module tb_qam_stream_modulator;
  localparam int CW    = 18;
  localparam int DEPTH = 16;
  localparam int OW    = CW + 5;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [15:0] per = 16'd1;
  logic [5:0] sym = '0;
  logic sym_valid = 1'b0;
  logic signed [CW-1:0] car_i = '0, car_q = '0;
  logic sym_ready, mod_valid, sym_strobe, underrun, busy;
  logic signed [OW-1:0] modulated;
  logic [$clog2(DEPTH):0] fifo_cnt;
`ifdef QAMMOD_UNDERRUN_CNT_EN
  logic urun_clr = 1'b0;
  logic [15:0] urun_cnt;
`endif

  qam_stream_modulator #(.CARRIER_W(CW), .FIFO_DEPTH(DEPTH)) dut (
    .ipClk(clk), .ipReset(rst_n), .ipEnable(en), .ipMode(mode), .ipSymPeriod(per),
    .ipSym(sym), .ipSymValid(sym_valid), .opSymReady(sym_ready), .ipI(car_i), .ipQ(car_q),
    .opModulated(modulated), .opModulatedValid(mod_valid), .opSymStrobe(sym_strobe),
    .opUnderrun(underrun),
`ifdef QAMMOD_UNDERRUN_CNT_EN
    .ipUnderrunClear(urun_clr), .opUnderrunCount(urun_cnt),
`endif
    .opFIFO_Count(fifo_cnt), .opBusy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint val;
    bit     strobe;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0, n_errors = 0;
  bit sb_on = 1'b1;
  int urun_seen = 0, run_len = 0, last_run = 0;
  int g2_tbl[4] = '{-6, -2, 6, 2};
  int g3_tbl[8] = '{-7, -5, -1, -3, 7, 5, 1, 3};

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void exp_levels(input logic [1:0] m, input logic [5:0] s,
                                     output int ai, output int aq);
    case (m)
      2'd0: begin ai = s[0] ? 7 : -7; aq = 0; end
      2'd1: begin ai = s[1] ? 5 : -5; aq = s[0] ? 5 : -5; end
      2'd2: begin ai = g2_tbl[s[3:2]]; aq = g2_tbl[s[1:0]]; end
      default: begin ai = g3_tbl[s[5:3]]; aq = g3_tbl[s[2:0]]; end
    endcase
  endfunction

  task automatic push_exp(input logic [5:0] s);
    int ai, aq, p;
    longint v;
    exp_levels(mode, s, ai, aq);
    p = (per == 16'd0) ? 1 : int'(per);
    v = longint'(car_i) * ai + longint'(car_q) * aq;
    for (int k = 0; k < p; k++) sb_q.push_back('{v, k == 0});
  endtask

  task automatic send_sym(input logic [5:0] s, input bit expect_it);
    int guard = 0;
    @(negedge clk);
    while (!sym_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!sym_ready) begin
      check_val("send_timeout", 0, 1);
    end else begin
      sym = s;
      sym_valid = 1'b1;
      if (expect_it) push_exp(s);
      @(posedge clk);
      #1 sym_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sb_q.size() != 0 || busy || mod_valid) && n < budget);
    if (sb_q.size() != 0 || busy || mod_valid) check_val("idle_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (underrun) urun_seen++;
      if (sym_strobe && !mod_valid) check_val("strobe_no_valid", 1, 0);
      if (mod_valid) begin
        run_len++;
        if (sb_on) begin
          if (sb_q.size() == 0) begin
            check_val("sb_extra_output", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check_val("modulated", longint'(modulated), e.val);
            check_val("strobe", longint'(sym_strobe), longint'(e.strobe));
          end
        end
      end else begin
        if (run_len != 0) last_run = run_len;
        run_len = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int u0, acc, guard;

    // Reset values.
    repeat (2) @(negedge clk);
    check_val("rst_ready", sym_ready, 0);
    check_val("rst_mod", modulated, 0);
    check_val("rst_valid", mod_valid, 0);
    check_val("rst_count", fifo_cnt, 0);
    check_val("rst_busy", busy, 0);
    rst_n = 1'b1;
    #1 check_val("ready_before_clk", sym_ready, 0);
    @(posedge clk);
    #1 check_val("ready_after_clk", sym_ready, 1);

    // QPSK back-to-back, period 4.
    mode = 2'd1; per = 16'd4; car_i = 1000; car_q = 0;
    send_sym(6'b000011, 1'b1);
    send_sym(6'b000000, 1'b1);
    check_val("qpsk_count", fifo_cnt, 2);
    u0 = urun_seen;
    @(negedge clk) en = 1'b1;
    wait_idle(100);
    check_val("qpsk_run_len", last_run, 8);
    check_val("qpsk_underrun", urun_seen - u0, 1);
    check_val("qpsk_mod_idle", modulated, 0);

    // 64-QAM at full negative carrier, period 1.
    mode = 2'd3; per = 16'd1; car_i = -131072; car_q = -131072;
    send_sym(6'b100000, 1'b1);
    send_sym(6'b100100, 1'b1);
    wait_idle(100);

    // BPSK with period 0 (one tick per symbol).
    mode = 2'd0; per = 16'd0; car_i = -3000; car_q = 777;
    send_sym(6'b000000, 1'b1);
    send_sym(6'b000001, 1'b1);
    send_sym(6'b101011, 1'b1);
    send_sym(6'b101010, 1'b1);
    wait_idle(100);

    // 16-QAM, period 2.
    mode = 2'd2; per = 16'd2; car_i = 12345; car_q = -2222;
    send_sym(6'b110000, 1'b1);
    send_sym(6'b000111, 1'b1);
    send_sym(6'b001101, 1'b1);
    send_sym(6'b001010, 1'b1);
    wait_idle(100);

    // Mode/period change mid-symbol only affects the next symbol.
    en = 1'b0; mode = 2'd1; per = 16'd5; car_i = 2000; car_q = 1000;
    send_sym(6'b000010, 1'b1);
    @(negedge clk) en = 1'b1;
    repeat (2) @(negedge clk);
    mode = 2'd0; per = 16'd2;
    send_sym(6'b000001, 1'b1);
    wait_idle(100);

    // Fill the FIFO while disabled; 17th offer refused.
    en = 1'b0; mode = 2'd1; per = 16'd3; car_i = 100; car_q = 200;
    acc = 0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      sym = 6'(i);
      sym_valid = 1'b1;
      if (sym_ready) acc++;
      if (i < DEPTH) push_exp(6'(i));
      @(posedge clk);
      #1;
    end
    sym_valid = 1'b0;
    check_val("full_accepted", acc, 16);
    check_val("full_count", fifo_cnt, 16);
    check_val("full_ready", sym_ready, 0);
    @(negedge clk) en = 1'b1;
    @(negedge clk) check_val("drain_count_a", fifo_cnt, 15);
    repeat (3) @(negedge clk);
    check_val("drain_count_b", fifo_cnt, 14);
    wait_idle(200);

    // Enable dropped mid-symbol: finish it, no underrun, FIFO keeps the rest.
    en = 1'b0; mode = 2'd1; per = 16'd4; car_i = 300; car_q = -400;
    send_sym(6'b000001, 1'b1);
    send_sym(6'b000010, 1'b0);
    u0 = urun_seen;
    @(negedge clk) en = 1'b1;
    repeat (2) @(negedge clk);
    en = 1'b0;
    wait_idle(100);
    check_val("halt_count", fifo_cnt, 1);
    check_val("halt_no_underrun", urun_seen - u0, 0);
    push_exp(6'b000010);
    @(negedge clk) en = 1'b1;
    wait_idle(100);
    check_val("halt_resume_underrun", urun_seen - u0, 1);

    // Reset mid-symbol with 5 queued.
    sb_on = 1'b0; en = 1'b0; mode = 2'd1; per = 16'd4; car_i = 1000; car_q = 0;
    for (int i = 0; i < 6; i++) send_sym(6'b000011, 1'b0);
    @(negedge clk) en = 1'b1;
    repeat (3) @(negedge clk);
    check_val("pre_rst_count", fifo_cnt, 5);
    check_val("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst_mod", modulated, 0);
    check_val("mid_rst_valid", mod_valid, 0);
    check_val("mid_rst_strobe", sym_strobe, 0);
    check_val("mid_rst_underrun", underrun, 0);
    check_val("mid_rst_count", fifo_cnt, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_ready", sym_ready, 0);
`ifdef QAMMOD_UNDERRUN_CNT_EN
    check_val("mid_rst_urun_cnt", urun_cnt, 0);
`endif
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("post_rst_ready", sym_ready, 1);
    check_val("post_rst_count", fifo_cnt, 0);
    sb_q.delete();
    sb_on = 1'b1;
    repeat (10) @(negedge clk);
    check_val("post_rst_busy", busy, 0);

    // Single symbol while enabled: one underrun at its end.
    mode = 2'd1; per = 16'd2; car_i = 50; car_q = 60;
    u0 = urun_seen;
    send_sym(6'b000010, 1'b1);
    wait_idle(100);
    check_val("single_underrun", urun_seen - u0, 1);
    check_val("single_mod_zero", modulated, 0);
    check_val("single_busy", busy, 0);
`ifdef QAMMOD_UNDERRUN_CNT_EN
    check_val("urun_cnt_one", urun_cnt, 1);
    send_sym(6'b000001, 1'b1);
    guard = 0;
    while (!underrun && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_val("urun_pulse_seen", underrun, 1);
    urun_clr = 1'b1;
    @(negedge clk) urun_clr = 1'b0;
    check_val("urun_clear_wins", urun_cnt, 0);
    wait_idle(100);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/qam_stream_modulator.md
QAM_STREAM_MODULATOR -- requirements
Module: qam_stream_modulator

Interface
REQ-001 SHALL provide parameters, one per line (name, default, meaning):
  CARRIER_W  18  signed width of carrier inputs ipI/ipQ
  FIFO_DEPTH  16  symbol FIFO depth, power of two, >=2
  OUT_W  CARRIER_W+5  derived, not overridable; width of opModulated
REQ-002 SHALL provide ports, one per line (name, direction, width, meaning):
  ipClk  in  1  sole clock, rising edge
  ipReset  in  1  asynchronous, active-low reset
  ipEnable  in  1  run permission
  ipMode  in  2  0 BPSK, 1 QPSK, 2 16-QAM, 3 64-QAM
  ipSymPeriod  in  16  clock ticks per symbol; 0 treated as 1
  ipSym  in  6  symbol bits
  ipSymValid  in  1  symbol offered
  opSymReady  out  1  FIFO not full
  ipI, ipQ  in  CARRIER_W  signed NCO carrier samples, one per clock
  opModulated  out  OUT_W  signed I*aI + Q*aQ
  opModulatedValid  out  1  opModulated carries an active symbol
  opSymStrobe  out  1  one-cycle pulse at each symbol start
  opUnderrun  out  1  one-cycle pulse, FIFO empty at symbol end while enabled
  opFIFO_Count  out  clog2(FIFO_DEPTH)+1  current occupancy
  opBusy  out  1  state is ACTIVE

Function
REQ-003 SHALL push ipSym when ipSymValid && opSymReady; opSymReady = (count < FIFO_DEPTH), registered-count based, no combinational path from ipSymValid.
REQ-004 SHALL allow push and pop in the same cycle; count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-005 SHALL implement states IDLE and ACTIVE; IDLE->ACTIVE when ipEnable && count>0 (pop, start symbol); ACTIVE holds symbol for max(ipSymPeriod,1) cycles.
REQ-006 SHALL at last tick of a symbol: pop next if ipEnable && count>0 (back-to-back, no gap); else go IDLE; pulse opUnderrun only if ipEnable && count==0.
REQ-007 SHALL latch ipMode and ipSymPeriod at symbol start; mid-symbol changes affect the next symbol only.
REQ-008 SHALL map levels (Gray): BPSK I=bit0 (0:-7, 1:+7), Q=0; QPSK I=bit1, Q=bit0 (0:-5, 1:+5); 16-QAM I=bits3:2, Q=bits1:0 (00:-6, 01:-2, 11:+2, 10:+6); 64-QAM I=bits5:3, Q=bits2:0 (000:-7, 001:-5, 011:-3, 010:-1, 110:+1, 111:+3, 101:+5, 100:+7); unused bits ignored.
REQ-009 SHALL force levels aI=aQ=0 in IDLE.
REQ-010 SHALL compute full-precision signed products (stage 1 registered) and their sum (stage 2 registered); latency 2 cycles from ipI/ipQ and level change to opModulated; no saturation (OUT_W covers worst case).
REQ-011 SHALL delay opModulatedValid and opSymStrobe through the same 2-stage pipeline so they align with opModulated.
REQ-012 SHALL, on ipEnable deassertion mid-symbol, complete current symbol then enter IDLE without underrun pulse; FIFO keeps accepting.

Reset
REQ-013 SHALL on ipReset low, asynchronously: state IDLE, pointers/count 0, levels 0, pipeline 0; opModulated 0, opModulatedValid 0, opSymStrobe 0, opUnderrun 0, opFIFO_Count 0, opBusy 0, opSymReady 0 while reset asserted, 1 from first clock after release.
REQ-014 SHALL discard FIFO contents and any in-progress symbol on reset mid-operation.

Configuration
REQ-015 SHALL, with QAMMOD_UNDERRUN_CNT_EN defined, add ports ipUnderrunClear (in, 1) and opUnderrunCount (out, 16): counter increments per opUnderrun, saturates at 65535, clear wins over simultaneous increment, reset to 0; without the macro these ports and logic are absent and all other behaviour is identical.

Verification
REQ-016 QPSK, period 4, ipI=1000, ipQ=0 constant, push 2'b11 then 2'b00 -> opModulated +5000 for 4 cycles then -5000 for 4, strobe at each start, no gap.
REQ-017 64-QAM, period 1, ipI=ipQ=-131072, sym 6'b100000 -> opModulated = -131072*7 + -131072*-7 = 0; sym 6'b100100 -> -1835008.
REQ-018 Push 17 symbols with ipEnable=0, DEPTH 16 -> opSymReady low after 16, count 16, 17th not accepted; enable -> count falls one per period.
REQ-019 Single symbol, ipEnable=1 -> one opUnderrun pulse at its end, opBusy low, opModulated 0 after 2 cycles; with macro, opUnderrunCount=1, clear+underrun same cycle -> 0.
REQ-020 Reset asserted mid-symbol with FIFO count 5 -> all outputs at reset values immediately, count 0 after release.
